// File: rtl/lz77_pkg.sv
// lz77_pkg
// Constants and state encoding shared by the LZ77 encoder and decoder.
//   SEARCH_DEPTH : search-buffer entries (legal offsets 0..SEARCH_DEPTH-1)
//   OFFSET_W     : offset field width
//   LEN_W        : match length field width
//   CHAR_W       : character width
//   END_CHAR     : terminator character ('$')
package lz77_pkg;

    localparam int SEARCH_DEPTH = 9;
    localparam int OFFSET_W     = 4;
    localparam int LEN_W        = 3;
    localparam int CHAR_W       = 8;

    localparam logic [CHAR_W-1:0]   END_CHAR  = 8'h24;
    // Depth expressed at offset width so the bounds compare is width-matched.
    localparam logic [OFFSET_W-1:0] DEPTH_IDX = OFFSET_W'(SEARCH_DEPTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        COPY = 2'd1,
        LIT  = 2'd2,
        DONE = 2'd3
    } lz77_state_e;

endpackage

// File: rtl/lz77_search_buf.sv
// lz77_search_buf
// Sliding search buffer for the LZ77 decoder: a SEARCH_DEPTH x CHAR_W shift
// register with entry 0 holding the most recent character.
// Ports:
//   clk      : rising-edge clock
//   reset    : synchronous active-high reset, clears every entry
//   shift_en : shift the buffer by one and insert din at entry 0
//   din      : character inserted on shift
//   rd_idx   : read index (0 = most recent)
//   rd_data  : entry at rd_idx, or 0 when rd_idx is out of range
//   rd_oob   : rd_idx >= SEARCH_DEPTH
module lz77_search_buf
    import lz77_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                shift_en,
    input  logic [CHAR_W-1:0]   din,
    input  logic [OFFSET_W-1:0] rd_idx,
    output logic [CHAR_W-1:0]   rd_data,
    output logic                rd_oob
);

    logic [CHAR_W-1:0] sbuf_q [SEARCH_DEPTH];
    logic [CHAR_W-1:0] sbuf_d [SEARCH_DEPTH];

    always_comb begin
        sbuf_d = sbuf_q;
        if (shift_en) begin
            sbuf_d[0] = din;
            for (int i = 1; i < SEARCH_DEPTH; i++) begin
                sbuf_d[i] = sbuf_q[i-1];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sbuf_q <= '{default: '0};
        end else begin
            sbuf_q <= sbuf_d;
        end
    end

    // Out-of-range reads return zero so the caller can keep the stream length.
    always_comb begin
        rd_oob  = (rd_idx >= DEPTH_IDX);
        rd_data = '0;
        if (!rd_oob) begin
            rd_data = sbuf_q[rd_idx];
        end
    end

endmodule

// File: rtl/lz77_decoder.sv
// lz77_decoder
// Rebuilds the character stream from (offset, match_len, char_nxt) tokens,
// emitting one character per cycle. A token whose literal is END_CHAR ends
// the stream: its copy part is emitted, the terminator itself is not.
//
// state | meaning
// IDLE  | ready for a token (code_ready = 1)
// COPY  | emitting one copied character per cycle from the search buffer
// LIT   | emitting the literal, or raising finish for the terminator
// DONE  | stream ended; tokens ignored until reset
//
// Ports:
//   clk, reset          : rising-edge clock, synchronous active-high reset
//   code_valid/ready    : token handshake (accepted when both are high)
//   offset, match_len   : copy distance (0 = most recent) and copy length
//   char_nxt            : literal following the copy
//   out_valid, out_char : decoded character stream
//   finish              : terminator consumed (sticky)
//   err                 : illegal offset used in a copy (sticky)
module lz77_decoder
    import lz77_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                code_valid,
    output logic                code_ready,
    input  logic [OFFSET_W-1:0] offset,
    input  logic [LEN_W-1:0]    match_len,
    input  logic [CHAR_W-1:0]   char_nxt,
    output logic                out_valid,
    output logic [CHAR_W-1:0]   out_char,
    output logic                finish,
    output logic                err
);

    lz77_state_e         state_q, state_d;
    logic [OFFSET_W-1:0] off_q, off_d;
    logic [LEN_W-1:0]    len_q, len_d;
    logic [CHAR_W-1:0]   lit_q, lit_d;
    logic                out_valid_q, out_valid_d;
    logic [CHAR_W-1:0]   out_char_q, out_char_d;
    logic                finish_q, finish_d;
    logic                err_q, err_d;

    logic                shift_en;
    logic [CHAR_W-1:0]   buf_din;
    logic [CHAR_W-1:0]   rd_data;
    logic                rd_oob;

    lz77_search_buf u_search_buf (
        .clk      (clk),
        .reset    (reset),
        .shift_en (shift_en),
        .din      (buf_din),
        .rd_idx   (off_q),
        .rd_data  (rd_data),
        .rd_oob   (rd_oob)
    );

    assign code_ready = (state_q == IDLE);

    always_comb begin
        state_d     = state_q;
        off_d       = off_q;
        len_d       = len_q;
        lit_d       = lit_q;
        out_valid_d = 1'b0;
        out_char_d  = out_char_q;
        finish_d    = finish_q;
        err_d       = err_q;
        shift_en    = 1'b0;
        buf_din     = lit_q;

        unique case (state_q)
            IDLE: begin
                if (code_valid) begin
                    off_d   = offset;
                    len_d   = match_len;
                    lit_d   = char_nxt;
                    state_d = (match_len != '0) ? COPY : LIT;
                end
            end
            COPY: begin
                // The buffer shifts as each copied character is written back,
                // so a fixed offset smaller than the length replays a run.
                out_valid_d = 1'b1;
                out_char_d  = rd_data;
                shift_en    = 1'b1;
                buf_din     = rd_data;
                len_d       = len_q - LEN_W'(1);
                if (rd_oob) begin
                    err_d = 1'b1;
                end
                if (len_q == LEN_W'(1)) begin
                    state_d = LIT;
                end
            end
            LIT: begin
                if (lit_q != END_CHAR) begin
                    out_valid_d = 1'b1;
                    out_char_d  = lit_q;
                    shift_en    = 1'b1;
                    state_d     = IDLE;
                end else begin
                    finish_d = 1'b1;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            off_q       <= '0;
            len_q       <= '0;
            lit_q       <= '0;
            out_valid_q <= 1'b0;
            out_char_q  <= '0;
            finish_q    <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            off_q       <= off_d;
            len_q       <= len_d;
            lit_q       <= lit_d;
            out_valid_q <= out_valid_d;
            out_char_q  <= out_char_d;
            finish_q    <= finish_d;
            err_q       <= err_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_char  = out_char_q;
    assign finish    = finish_q;
    assign err       = err_q;

endmodule

// File: tb/tb_lz77_decoder.sv
module tb_lz77_decoder;
    import lz77_pkg::*;

    logic                clk = 1'b0;
    logic                reset = 1'b1;
    logic                code_valid = 1'b0;
    logic                code_ready;
    logic [OFFSET_W-1:0] offset = '0;
    logic [LEN_W-1:0]    match_len = '0;
    logic [CHAR_W-1:0]   char_nxt = '0;
    logic                out_valid;
    logic [CHAR_W-1:0]   out_char;
    logic                finish;
    logic                err;

    lz77_decoder dut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .code_ready (code_ready),
        .offset     (offset),
        .match_len  (match_len),
        .char_nxt   (char_nxt),
        .out_valid  (out_valid),
        .out_char   (out_char),
        .finish     (finish),
        .err        (err)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    // Reference model: the whole decoded history, seeded with the zeroed window.
    logic [7:0] hist  [$];
    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];
    bit         m_done;
    bit         m_err;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, expv);
        end
    endtask

    always @(posedge clk) begin
        #1;
        if (out_valid === 1'b1) got_q.push_back(out_char);
    end

    task automatic model_init();
        hist.delete();
        for (int i = 0; i < SEARCH_DEPTH; i++) hist.push_back(8'h00);
        exp_q.delete();
        got_q.delete();
        m_done = 0;
        m_err  = 0;
    endtask

    task automatic model_token(input int off, input int len, input logic [7:0] ch);
        logic [7:0] c;
        if (m_done) return;
        for (int k = 0; k < len; k++) begin
            if (off < SEARCH_DEPTH) c = hist[hist.size() - 1 - off];
            else begin
                c = 8'h00;
                m_err = 1;
            end
            hist.push_back(c);
            exp_q.push_back(c);
        end
        if (ch == 8'h24) m_done = 1;
        else begin
            hist.push_back(ch);
            exp_q.push_back(ch);
        end
    endtask

    task automatic do_reset(input int cycles);
        reset = 1'b1;
        code_valid = 1'b0;
        repeat (cycles) @(posedge clk);
        #1;
        reset = 1'b0;
        model_init();
    endtask

    // Present one token; returns #1 after the acceptance edge.
    task automatic send(input int off, input int len, input logic [7:0] ch);
        int n;
        n = 0;
        if (!m_done) begin
            while (code_ready !== 1'b1 && n < 40) begin
                @(posedge clk);
                #1;
                n++;
            end
            if (code_ready !== 1'b1) chk("ready_timeout", 0, 1);
        end
        offset     = OFFSET_W'(off);
        match_len  = LEN_W'(len);
        char_nxt   = ch;
        code_valid = 1'b1;
        @(posedge clk);
        #1;
        code_valid = 1'b0;
        model_token(off, len, ch);
    endtask

    task automatic drain_compare(input string tag);
        int n;
        repeat (12) @(posedge clk);
        #2;
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) chk($sformatf("%s_char%0d", tag, i), got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        model_init();
        do_reset(3);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_char", out_char, 0);
        chk("rst_finish", finish, 0);
        chk("rst_err", err, 0);
        chk("rst_ready", code_ready, 1);

        // Literal-only token: output on the LIT edge, ready low for one cycle.
        send(0, 0, "A");
        chk("lit_ready_low", code_ready, 0);
        @(posedge clk); #1;
        chk("lit_valid", out_valid, 1);
        chk("lit_char", out_char, "A");
        chk("lit_ready_back", code_ready, 1);
        @(posedge clk); #1;
        chk("lit_valid_once", out_valid, 0);
        send(0, 0, "B");
        send(0, 0, "C");
        send(2, 3, "D");
        drain_compare("copy");

        do_reset(2);
        send(0, 0, "A");
        send(0, 5, "B");
        drain_compare("overlap");

        do_reset(2);
        send(12, 2, "Z");
        drain_compare("oob");
        chk("oob_err", err, 1);
        send(0, 0, "K");
        drain_compare("oob_after");
        chk("oob_err_sticky", err, 1);

        do_reset(2);
        send(0, 0, "X");
        send(0, 0, "Y");
        send(1, 2, 8'h24);
        drain_compare("term");
        chk("term_finish", finish, 1);
        chk("term_ready", code_ready, 0);
        send(0, 0, "W");
        send(0, 3, "V");
        drain_compare("term_ignored");
        chk("term_finish_held", finish, 1);

        // Reset landing on the third COPY cycle of a length-7 token.
        do_reset(2);
        send(0, 0, "M");
        send(0, 7, "N");
        @(posedge clk); #1;
        @(posedge clk); #1;
        do_reset(1);
        chk("midrst_valid", out_valid, 0);
        chk("midrst_ready", code_ready, 1);
        send(0, 1, "Q");
        drain_compare("midrst");

        for (int t = 0; t < 6; t++) begin
            int ntok;
            do_reset(2);
            ntok = $urandom_range(6, 14);
            for (int k = 0; k < ntok; k++) begin
                int off;
                int len;
                logic [7:0] ch;
                off = ($urandom_range(0, 5) == 0) ? $urandom_range(9, 15) : $urandom_range(0, 8);
                len = $urandom_range(0, 7);
                ch  = 8'($urandom_range(0, 255));
                if (ch == 8'h24) ch = 8'h41;
                if ((t % 2 == 1) && k == ntok - 1) ch = 8'h24;
                send(off, len, ch);
            end
            drain_compare($sformatf("rnd%0d", t));
            chk($sformatf("rnd%0d_err", t), err, m_err);
            chk($sformatf("rnd%0d_finish", t), finish, m_done);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

endmodule
